// File: rtl/memory_pkg.sv
// Shared constants for the memory FIFO: default geometry and the pointer/count widths.
// The optional status-flag ports are enabled with MEMORY_FLAGS_EN (see memory.sv).
package memory_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 16;
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = PTR_W_DEF + 1;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/memory_ram.sv
// FIFO storage array: synchronous write, asynchronous read, contents never reset.
module memory_ram #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory.sv
// Synchronous FIFO with registered read data on a tristate bus (status=1 releases the bus).
// Define MEMORY_FLAGS_EN to expose the emp/full/half/idle flag ports.
module memory
    import memory_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk_in,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] data_in,
    input  logic             status,
    input  logic             rst,
    output logic [WIDTH-1:0] data_out
`ifdef MEMORY_FLAGS_EN
    ,
    output logic             emp,
    output logic             full,
    output logic             half,
    output logic             idle
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] ram_rdata;
    logic             emp_int;
    logic             full_int;
    logic             wr_ok;
    logic             rd_ok;

    assign emp_int  = (count == '0);
    assign full_int = (count == CNT_W'(DEPTH));

    // When full, a simultaneous read frees the slot the write lands in; the RAM
    // read is asynchronous so the old entry is captured before it is overwritten.
    assign rd_ok = rd && !emp_int;
    assign wr_ok = wr && (!full_int || rd_ok);

    memory_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk_in (clk_in),
        .we     (wr_ok),
        .waddr  (wr_ptr),
        .wdata  (data_in),
        .raddr  (rd_ptr),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                out_reg <= ram_rdata;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign data_out = status ? {WIDTH{1'bz}} : out_reg;

`ifdef MEMORY_FLAGS_EN
    assign emp  = emp_int;
    assign full = full_int;
    assign half = (count >= CNT_W'(DEPTH / 2));
    assign idle = !wr && !rd;
`endif

endmodule

// File: tb/tb_memory.sv
// Scoreboarded random/directed bench for the memory FIFO against a queue-based model.
module tb_memory;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b0;
    logic             wr     = 1'b0;
    logic             rd     = 1'b0;
    logic             status = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    wire  [WIDTH-1:0] data_out;
`ifdef MEMORY_FLAGS_EN
    wire emp, full, half, idle;
`endif

    memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_in   (clk_in),
        .wr       (wr),
        .rd       (rd),
        .data_in  (data_in),
        .status   (status),
        .rst      (rst),
        .data_out (data_out)
`ifdef MEMORY_FLAGS_EN
        ,
        .emp      (emp),
        .full     (full),
        .half     (half),
        .idle     (idle)
`endif
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model_q [$];   // FIFO contents as the spec describes them
    logic [WIDTH-1:0] sb_q [$];      // expected read results, in order
    logic [WIDTH-1:0] exp_hold = '0; // value the output register must hold

    task automatic check(input string name, input bit ok, input logic [31:0] act, input string req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %b, required %s", name, act, req);
        end
    endtask

    // One clock cycle of stimulus; the model decides acceptance from occupancy alone.
    task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit s);
        bit rd_acc, wr_acc;
        @(negedge clk_in);
        wr = w; rd = r; data_in = d; status = s;
        rd_acc = r && (model_q.size() > 0);
        wr_acc = w && ((model_q.size() < DEPTH) || rd_acc);
        if (rd_acc) sb_q.push_back(model_q.pop_front());
        if (wr_acc) model_q.push_back(d);
        @(posedge clk_in);
    endtask

    // Monitor: after each edge, pop the expected read result (if any) and compare.
    always @(posedge clk_in) begin
        #1;
        if (rst) begin
            if (sb_q.size() > 0) exp_hold = sb_q.pop_front();
            if (status == 1'b0)
                check("data_out", data_out === exp_hold, 32'(data_out), $sformatf("%b", exp_hold));
`ifdef MEMORY_FLAGS_EN
            check("emp",  emp  === (model_q.size() == 0),        32'(emp),  $sformatf("%0d", model_q.size() == 0));
            check("full", full === (model_q.size() == DEPTH),    32'(full), $sformatf("%0d", model_q.size() == DEPTH));
            check("half", half === (model_q.size() >= DEPTH/2),  32'(half), $sformatf("%0d", model_q.size() >= DEPTH/2));
            check("idle", idle === (!wr && !rd),                 32'(idle), $sformatf("%0d", !wr && !rd));
`endif
        end
    end

    task automatic mid_reset(input string name);
        #3;
        wr = 1'b0; rd = 1'b0; status = 1'b0;
        rst = 1'b0;
        model_q.delete();
        sb_q.delete();
        exp_hold = '0;
        #1;
        check({name, "_data"}, data_out === '0, 32'(data_out), "0000");
`ifdef MEMORY_FLAGS_EN
        check({name, "_emp"}, emp === 1'b1, 32'(emp), "1");
`endif
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] pat [3];
        pat[0] = 4'b1001; pat[1] = 4'b1101; pat[2] = 4'b0011;

        // Reset acts without any clock edge.
        #1;
        check("reset_data", data_out === 4'b0000, 32'(data_out), "0000");
`ifdef MEMORY_FLAGS_EN
        check("reset_emp",  emp === 1'b1,  32'(emp),  "1");
        check("reset_idle", idle === 1'b1, 32'(idle), "1");
`endif
        @(negedge clk_in);
        rst = 1'b1;

        // Three writes then three reads.
        for (int i = 0; i < 3; i++) cycle(1, 0, pat[i], 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'h0, 0);
        cycle(0, 1, 4'h0, 0);  // read on empty must hold 0011

        // Fill past full; overflow writes must be dropped.
        for (int i = 0; i < 20; i++) cycle(1, 0, 4'b1001, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 4'h0, 0);
        cycle(1, 0, 4'b0110, 0);
        cycle(0, 1, 4'h0, 0);  // must be 0110, not a stale 1001

        // Read on empty, then wr+rd on empty is a write only.
        cycle(0, 1, 4'h0, 0);
        cycle(1, 1, 4'b0101, 0);
        cycle(0, 0, 4'h0, 0);
        cycle(0, 1, 4'h0, 0);

        // Full with simultaneous wr+rd: both happen.
        for (int i = 0; i < 16; i++) cycle(1, 0, 4'(i), 0);
        cycle(1, 1, 4'b1111, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 4'h0, 0);

        // Bus release with the stored value held.
        cycle(1, 0, 4'b1010, 0);
        cycle(1, 0, 4'b0111, 0);
        cycle(0, 1, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 4'h0, 1);
            check("status_release", data_out !== 4'b1010, 32'(data_out), "not 1010 (released)");
            cycle(0, 0, 4'h0, 0);
        end
        cycle(0, 1, 4'h0, 0);  // remaining 0111 still stored

        // Reset between edges with five entries stored.
        for (int i = 0; i < 6; i++) cycle(1, 0, 4'(i + 9), 0);
        cycle(0, 1, 4'h0, 0);
        mid_reset("midreset");
        cycle(0, 1, 4'h0, 0);  // empty after reset: output stays 0
        cycle(1, 0, 4'b1100, 0);
        cycle(0, 1, 4'h0, 0);

        // Random traffic with drifting write/read bias.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 200) ? 75 : (i < 400) ? 25 : 50;
            cycle($urandom_range(99) < wp, $urandom_range(99) < (100 - wp),
                  4'($urandom_range(15)), $urandom_range(3) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 4'h0, 0);
        cycle(0, 0, 4'h0, 0);

        check("sb_drained", sb_q.size() == 0, 32'(sb_q.size()), "0");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
